// File: rtl/neuro_skin_pkg.sv
`default_nettype none
// ============================================================================
// Module  : neuro_skin_pkg
// Brief   : Shared types and pixel helpers for the skin frame scanout path.
// Revision: 1.0
// ============================================================================
package neuro_skin_pkg;

    localparam int c_pix_w = 25;   // {skin, R, G, B}
    localparam int c_out_w = 32;   // {7'b0, skin, R, G, B}

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VFRONT = 3'd1,
        S_ACTIVE = 3'd2,
        S_HBL    = 3'd3,
        S_VBACK  = 3'd4,
        S_VLOWS  = 3'd5
    } scan_state_t;

    // Masking is applied on the write side so the RAM output is the display word.
    function automatic logic [c_pix_w-1:0] mask_pixel(
        input logic [23:0] i_rgb,
        input logic        i_skin,
        input logic        i_mask_mode,
        input int unsigned i_dim_shift
    );
        logic [7:0] w_r;
        logic [7:0] w_g;
        logic [7:0] w_b;
        w_r = i_rgb[23:16] >> i_dim_shift;
        w_g = i_rgb[15:8]  >> i_dim_shift;
        w_b = i_rgb[7:0]   >> i_dim_shift;
        if (i_skin)
            mask_pixel = {1'b1, i_rgb};
        else if (i_mask_mode)
            mask_pixel = {1'b0, w_r, w_g, w_b};
        else
            mask_pixel = '0;
    endfunction

    function automatic logic [c_out_w-1:0] pack_out(input logic [c_pix_w-1:0] i_pix);
        pack_out = {{(c_out_w - c_pix_w){1'b0}}, i_pix};
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_bank_ram.sv
`default_nettype none
// ============================================================================
// Module  : scan_bank_ram
// Brief   : Simple dual-port RAM, one write port, one registered read port.
// Revision: 1.0
// ============================================================================
module scan_bank_ram #(
    parameter int DW = 25,
    parameter int AW = 9
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    // Read data only moves on a read, so the output holds between lines.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_rdata <= '0;
        else if (i_re)
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/skin_frame_scanout.sv
`default_nettype none
// ============================================================================
// Module  : skin_frame_scanout
// Brief   : Ping-pong frame buffer with VGA-style vs/de scanout of masked pixels.
// Revision: 1.0
// ============================================================================
module skin_frame_scanout
    import neuro_skin_pkg::*;
#(
    parameter int W         = 16,
    parameter int H         = 16,
    parameter int HBLANK    = 4,
    parameter int VFRONT    = 2,
    parameter int VBACK     = 2,
    parameter int VLOW      = 4,
    parameter int MASK_MODE = 1,
    parameter int DIM_SHIFT = 2
) (
    input  logic        vga_clk,
    input  logic        vga_rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sof,
    input  logic [23:0] in_rgb,
    input  logic        in_skin,
    output logic        vga_vs,
    output logic        vga_de,
    output logic [31:0] vga_data1,
    output logic [7:0]  frames_dropped
);

    localparam int c_npix = W * H;
    localparam int c_aw   = $clog2(c_npix);
    localparam int c_cw   = 16;

    localparam logic [c_aw-1:0] c_last_addr = c_aw'(c_npix - 1);
    localparam logic [c_cw-1:0] c_w_last    = c_cw'(W - 1);
    localparam logic [c_cw-1:0] c_h_last    = c_cw'(H - 1);
    localparam logic [c_cw-1:0] c_vf_last   = c_cw'(VFRONT - 1);
    localparam logic [c_cw-1:0] c_hb_last   = c_cw'(HBLANK - 1);
    localparam logic [c_cw-1:0] c_vb_last   = c_cw'(VBACK - 1);
    localparam logic [c_cw-1:0] c_vl_last   = c_cw'(VLOW - 1);

    // ------------------------------------------------------------------ writer
    logic              r_wbank;
    logic              r_armed;
    logic              r_pending;
    logic [c_aw-1:0]   r_waddr;
    logic [7:0]        r_drop;

    logic              w_accept;
    logic              w_swap;
    logic              w_last_wr;
    logic              w_we;
    logic              w_wr_bank;
    logic [c_aw-1:0]   w_waddr_sel;
    logic [c_pix_w-1:0] w_wdata;

    scan_state_t       r_state;
    scan_state_t       w_state_nxt;

    assign w_swap      = r_pending && (r_state == S_IDLE);
    // In the swap cycle the writer already targets the freshly released bank.
    assign in_ready    = !r_pending || w_swap;
    assign w_accept    = in_valid && in_ready;
    assign w_we        = w_accept && (in_sof || r_armed);
    assign w_last_wr   = w_accept && !in_sof && r_armed && (r_waddr == c_last_addr);
    assign w_wr_bank   = w_swap ? ~r_wbank : r_wbank;
    assign w_waddr_sel = in_sof ? '0 : r_waddr;
    assign w_wdata     = mask_pixel(in_rgb, in_skin, (MASK_MODE != 0), DIM_SHIFT);

    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            r_wbank   <= 1'b0;
            r_armed   <= 1'b0;
            r_pending <= 1'b0;
            r_waddr   <= '0;
            r_drop    <= '0;
        end else begin
            if (w_swap)
                r_wbank <= ~r_wbank;

            if (w_last_wr)
                r_pending <= 1'b1;
            else if (w_swap)
                r_pending <= 1'b0;

            if (w_accept && in_sof) begin
                r_armed <= 1'b1;
                r_waddr <= c_aw'(1);
                if (r_armed && (r_drop != 8'hFF))
                    r_drop <= r_drop + 8'd1;
            end else if (w_accept && r_armed) begin
                if (w_last_wr)
                    r_armed <= 1'b0;
                r_waddr <= r_waddr + 1'b1;
            end
        end
    end

    // ----------------------------------------------------------------- scanout
    logic [c_cw-1:0]   r_cnt;
    logic [c_cw-1:0]   w_cnt_nxt;
    logic [c_cw-1:0]   r_line;
    logic [c_cw-1:0]   w_line_nxt;
    logic [c_aw-1:0]   r_raddr;
    logic              r_vs;
    logic              w_rd_en;
    logic [c_pix_w-1:0] w_rdata;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_line_nxt  = r_line;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_swap)
                    w_state_nxt = S_VFRONT;
            end
            S_VFRONT: begin
                if (r_cnt == c_vf_last) begin
                    w_state_nxt = S_ACTIVE;
                    w_cnt_nxt   = '0;
                    w_line_nxt  = '0;
                end
            end
            S_ACTIVE: begin
                if (r_cnt == c_w_last) begin
                    w_cnt_nxt = '0;
                    if (r_line == c_h_last)
                        w_state_nxt = (VBACK > 0) ? S_VBACK : ((VLOW > 0) ? S_VLOWS : S_IDLE);
                    else if (HBLANK > 0)
                        w_state_nxt = S_HBL;
                    else
                        w_line_nxt = r_line + 1'b1;
                end
            end
            S_HBL: begin
                if (r_cnt == c_hb_last) begin
                    w_state_nxt = S_ACTIVE;
                    w_cnt_nxt   = '0;
                    w_line_nxt  = r_line + 1'b1;
                end
            end
            S_VBACK: begin
                if (r_cnt == c_vb_last) begin
                    w_state_nxt = (VLOW > 0) ? S_VLOWS : S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            S_VLOWS: begin
                if (r_cnt == c_vl_last) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Strobes are registered from the next state so they line up with RAM data.
    assign w_rd_en = (w_state_nxt == S_ACTIVE);

    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_line  <= '0;
            r_raddr <= '0;
            r_vs    <= 1'b0;
            vga_de  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_line  <= w_line_nxt;
            if (w_swap)
                r_raddr <= '0;
            else if (w_rd_en)
                r_raddr <= r_raddr + 1'b1;
            r_vs    <= (w_state_nxt == S_VFRONT) || (w_state_nxt == S_ACTIVE) ||
                       (w_state_nxt == S_HBL)    || (w_state_nxt == S_VBACK);
            vga_de  <= w_rd_en;
        end
    end

    scan_bank_ram #(
        .DW (c_pix_w),
        .AW (c_aw + 1)
    ) u_ram (
        .i_clk   (vga_clk),
        .i_rst_n (vga_rst_n),
        .i_we    (w_we),
        .i_waddr ({w_wr_bank, w_waddr_sel}),
        .i_wdata (w_wdata),
        .i_re    (w_rd_en),
        .i_raddr ({~r_wbank, r_raddr}),
        .o_rdata (w_rdata)
    );

    assign vga_vs         = r_vs;
    assign vga_data1      = pack_out(w_rdata);
    assign frames_dropped = r_drop;

endmodule
`default_nettype wire

// File: doc/skin_frame_scanout.md
# skin_frame_scanout

Ping-pong frame buffer and video-timing generator that collects a 16x16 classified pixel stream (RGB plus per-pixel skin decision from the neural classifier) and replays each completed frame as a `vga_vs`/`vga_de`/`vga_data1` stream. Sits directly upstream of the simulation PPM frame logger and of any display sink. Frames are gated so that `vga_vs` high brackets exactly one frame's active pixels.

## Interface
- `W`, 16: pixels per line.
- `H`, 16: lines per frame.
- `HBLANK`, 4: de-low cycles between lines (vs stays high).
- `VFRONT`, 2: cycles from `vga_vs` rise to first `vga_de`; must be >= 1.
- `VBACK`, 2: cycles from last `vga_de` to `vga_vs` fall.
- `VLOW`, 4: minimum `vga_vs` low cycles between frames.
- `MASK_MODE`, 1: 0 = non-skin pixels black, 1 = non-skin pixels dimmed.
- `DIM_SHIFT`, 2: per-channel right shift for dimmed pixels.

- `vga_clk` in 1: single clock for all logic.
- `vga_rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: input pixel valid.
- `in_ready` out 1: pixel accepted when `in_valid && in_ready`.
- `in_sof` in 1: accepted pixel is pixel (0,0) of a frame.
- `in_rgb` in 24: {R,G,B}, 8 bits each.
- `in_skin` in 1: classifier decision for this pixel.
- `vga_vs` out 1: high for the whole frame window.
- `vga_de` out 1: active-pixel strobe.
- `vga_data1` out 32: {7'b0, skin, R, G, B} after masking.
- `frames_dropped` out 8: saturating count of incomplete frames discarded.

## Operation
- Two banks, each W*H x 25 bits ({skin,rgb}). Writer owns one bank, scanout owns the other.
- Writer: an accepted pixel with `in_sof`=1 writes address 0 and arms the writer; subsequent accepted pixels write addresses 1..W*H-1 in raster order. Accepted pixels while unarmed are discarded.
- An `in_sof` pixel arriving before address W*H-1 is written restarts at 0; `frames_dropped` increments (saturates at 255).
- After address W*H-1 is written, the bank is complete and the writer disarms. If scanout is IDLE, banks swap on the next cycle; otherwise the bank is held pending and `in_ready` = 0 until scanout returns to IDLE, then banks swap and `in_ready` = 1.
- Scanout FSM: IDLE -> VFRONT (vs=1) -> ACTIVE (W cycles de=1) -> HBL (HBLANK cycles) -> ACTIVE ... ; after line H-1 ACTIVE goes directly to VBACK (vs=1, de=0) -> VLOWS (VLOW cycles vs=0) -> IDLE. IDLE leaves on a swap.
- Output pixel: skin=1 -> rgb unchanged; skin=0 -> 0 (MASK_MODE 0) or each channel >> DIM_SHIFT (MASK_MODE 1). Bit 24 = skin, [31:25] = 0.
- `vga_data1` holds its last value while `vga_de`=0.

## Timing
- Reset values: `vga_vs`=0, `vga_de`=0, `vga_data1`=0, `frames_dropped`=0, `in_ready`=1, both banks free, writer unarmed, FSM IDLE.
- Reset mid-frame: outputs drop to 0 asynchronously; buffered frames are lost.
- RAM read is synchronous (1 cycle); address is issued one cycle ahead so `vga_vs`, `vga_de`, `vga_data1` are registered and mutually aligned.
- `vga_de` is never high in the cycle `vga_vs` rises; first `vga_de` is exactly VFRONT cycles after the rise.
- vs-high window = VFRONT + W*H + (H-1)*HBLANK + VBACK cycles (320 with defaults); frame period >= that + VLOW (324).
- Swap to `vga_vs` rise: 2 cycles after the write of the last pixel.
- Simultaneous final write and scanout return to IDLE: swap occurs, no stall.

## Structure
- Shared package `neuro_skin_pkg`: scanout state encoding, pixel word width (25), output packing layout.
- One sub-module `scan_bank_ram`: simple dual-port RAM, 1 write port, 1 synchronous read port, depth 2*W*H (bank bit as address MSB).

## Test plan
- One frame, pixel i = {R=i, G=255-i, B=0x55}, skin=i[0], MASK_MODE 1 -> 256 `vga_de` pixels; odd i unchanged, even i = {i>>2, (255-i)>>2, 0x15}; bit 24 = i[0].
- Timing check, defaults -> vs high exactly 320 cycles; de pattern 16 on / 4 off, 16 lines; first de 2 cycles after vs rise.
- Two frames back-to-back at full rate -> `in_ready` low from frame-2 completion until frame-1 VLOWS ends; both frames output intact, in order.
- `in_sof` after 100 pixels -> `frames_dropped`=1, only the restarted frame is output.
- Pixels before any `in_sof` -> discarded, no `vga_vs` activity.
- Assert `vga_rst_n` mid-ACTIVE -> `vga_vs`/`vga_de` 0 immediately; after release, new frame scans out normally.
